prime_candidate_gen: RTL and testbench
======================================

Name: prime_candidate_gen

Overview:
- Sits directly downstream of the free-running LFSR random source in the RSA key-generation path.
- On request, packs consecutive (WORD_WIDTH/2)-bit random words into one CAND_WIDTH-bit odd, full-width prime candidate.
- Rejects candidates divisible by 3 and re-collects until one passes.
- Offers the passing candidate on a valid/ready interface to the primality-test stage.

Parameters:
- WORD_WIDTH, 32, system word width; random chunk width CW = WORD_WIDTH/2.
- CAND_WIDTH, 32, candidate width; must be a multiple of CW and >= CW. NUM_CHUNKS = CAND_WIDTH/CW.
- REJ_CNT_WIDTH, 8, width of the saturating reject counter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request one candidate; honoured only in IDLE.
- rand_in, input, CW, random word from the LFSR; new value every cycle, no valid qualifier.
- cand_valid, output, 1, cand_out holds an accepted candidate.
- cand_ready, input, 1, consumer accepts the candidate.
- cand_out, output, CAND_WIDTH, assembled candidate.
- busy, output, 1, high in every state except IDLE.
- reject_cnt, output, REJ_CNT_WIDTH, number of candidates rejected since reset; saturates.

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: state IDLE, cand_valid 0, cand_out 0, busy 0, reject_cnt 0, chunk index 0, residue 0.
- FSM states IDLE, COLLECT, CHECK, HOLD.
  - IDLE: start=1 at an edge moves to COLLECT and clears the index and residue.
  - COLLECT: samples rand_in on each of NUM_CHUNKS consecutive edges.
    - Chunk i goes to cand_out[i*CW +: CW]; chunk 0 is the least significant and is collected first.
    - Chunk 0 has bit 0 forced to 1. Chunk NUM_CHUNKS-1 has bit CW-1 forced to 1. With NUM_CHUNKS=1, both bits are forced on the same chunk.
    - residue <= (residue + (forced chunk mod 3)) mod 3. This is valid because 2^CW ≡ 1 (mod 3) for even CW.
    - After the last chunk, move to CHECK.
  - CHECK (1 cycle): if residue==0, increment reject_cnt (saturating at all-ones), clear the index and residue, and return to COLLECT. Otherwise move to HOLD.
  - HOLD: cand_valid=1 and cand_out stable. When cand_valid and cand_ready are both high at an edge, return to IDLE; cand_valid is 0 the following cycle.
- Latency: for a start edge at cycle 0, with no rejects and cand_ready held high, cand_valid rises at cycle NUM_CHUNKS+2, and the handshake completes on that same cycle's closing edge. Each reject adds NUM_CHUNKS+1 cycles.
- cand_ready is ignored outside HOLD. start is ignored outside IDLE, including start held high during HOLD.
- start in the same cycle as a HOLD handshake is ignored; a new start is needed in IDLE. Back-to-back candidates therefore require at least one IDLE cycle.
- cand_out retains its value after a handshake until the next COLLECT overwrites it. It is only meaningful while cand_valid is high.
- The candidate always has its MSB set, so it is never the value 3 itself; rejecting every multiple of 3 is correct.
- rst asserted at any point, including mid-COLLECT or during HOLD, returns immediately to the reset values; a partial candidate is discarded.
- reject_cnt is not cleared by start.

Test Plan:
- Reset then idle: busy=0, cand_valid=0, cand_out=0, reject_cnt=0; with no start, outputs stay constant for 20 cycles.
- Accept path (defaults): start, rand_in=0x1234 then 0x5679 -> chunks 0x1235 and 0xD679 (residue 2+2 -> 1). cand_out=0xD6791235, cand_valid high at cycle 4 after start, reject_cnt=0.
- Reject then accept: rand_in=0x1234, 0x5678 (0xD6781235, residue 0) -> reject_cnt=1, re-collect. Then 0x0002, 0x0000 -> cand_out=0x80000003 valid, reject_cnt=1.
- Backpressure: hold cand_ready=0 for 10 cycles in HOLD -> cand_valid and cand_out stable, start pulses ignored. Raise cand_ready -> one-cycle handshake, then IDLE with busy=0.
- Reset mid-operation: assert rst after the first chunk -> busy=0, cand_out=0 asynchronously. A new start then yields a fresh candidate built only from post-reset rand_in.
- Saturation: with rand_in forced to 0x0000 (candidate 0x80000001 ≡ 0 mod 3), run 300 rejects -> reject_cnt stops at 255 and cand_valid never rises.

Source files
------------

// File: rtl/prime_candidate_gen.sv
// Purpose: packs random LFSR chunks into an odd, full-width candidate and rejects multiples of 3.
// Latency: NUM_CHUNKS+2 cycles from start to cand_valid; each reject adds NUM_CHUNKS+1 cycles.
// Backpressure: the candidate is held in HOLD until cand_ready; start is ignored while busy.
module prime_candidate_gen #(
    parameter int WORD_WIDTH    = 32,
    parameter int CAND_WIDTH    = 32,
    parameter int REJ_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WORD_WIDTH/2-1:0]  rand_in,
    output logic                     cand_valid,
    input  logic                     cand_ready,
    output logic [CAND_WIDTH-1:0]    cand_out,
    output logic                     busy,
    output logic [REJ_CNT_WIDTH-1:0] reject_cnt
);

    localparam int CW         = WORD_WIDTH / 2;
    localparam int NUM_CHUNKS = CAND_WIDTH / CW;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         residue;
    logic [CW-1:0]      forced;
    logic [1:0]         chunk_res;
    logic               last_chunk;

    // (a + b) mod 3 for operands already reduced to 0..2 (or a raw base-4 digit 0..3)
    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Since 4 == 1 (mod 3), a value mod 3 is the sum of its base-4 digits mod 3
    function automatic logic [1:0] mod3(input logic [CW-1:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < CW / 2; k++) begin
            r = add_mod3(r, v[2*k +: 2]);
        end
        return r;
    endfunction

    assign last_chunk = (idx == IDX_W'(NUM_CHUNKS - 1));

    // Force odd LSB on the first chunk and the MSB on the last chunk
    always_comb begin
        forced = rand_in;
        if (idx == '0) begin
            forced[0] = 1'b1;
        end
        if (last_chunk) begin
            forced[CW-1] = 1'b1;
        end
    end

    assign chunk_res = mod3(forced);

    // Control FSM with registered outputs and the candidate datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            residue    <= 2'd0;
            cand_valid <= 1'b0;
            cand_out   <= '0;
            busy       <= 1'b0;
            reject_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= COLLECT;
                        idx     <= '0;
                        residue <= 2'd0;
                        busy    <= 1'b1;
                    end
                end
                COLLECT: begin
                    for (int i = 0; i < NUM_CHUNKS; i++) begin
                        if (idx == IDX_W'(i)) begin
                            cand_out[i*CW +: CW] <= forced;
                        end
                    end
                    residue <= add_mod3(residue, chunk_res);
                    if (last_chunk) begin
                        state <= CHECK;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                CHECK: begin
                    if (residue == 2'd0) begin
                        if (reject_cnt != '1) begin
                            reject_cnt <= reject_cnt + REJ_CNT_WIDTH'(1);
                        end
                        idx     <= '0;
                        residue <= 2'd0;
                        state   <= COLLECT;
                    end else begin
                        cand_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (cand_ready) begin
                        cand_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cand_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_candidate_gen.sv
// Bench for prime_candidate_gen: scoreboarded candidate requests, backpressure, reset and saturation.
module tb_prime_candidate_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] rand_in;
    logic        cand_valid;
    logic        cand_ready;
    logic [31:0] cand_out;
    logic        busy;
    logic [7:0]  reject_cnt;

    int checks = 0;
    int errors = 0;
    int exp_rej = 0;

    logic [15:0] stim_q[$];
    logic [31:0] exp_q[$];

    prime_candidate_gen #(
        .WORD_WIDTH(32),
        .CAND_WIDTH(32),
        .REJ_CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rand_in(rand_in),
        .cand_valid(cand_valid),
        .cand_ready(cand_ready),
        .cand_out(cand_out),
        .busy(busy),
        .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue one collection attempt; an accepted candidate goes to the scoreboard
    task automatic plan(input logic [15:0] c0, input logic [15:0] c1, output bit rejected);
        logic [31:0] c;
        c = {c1 | 16'h8000, c0 | 16'h0001};
        stim_q.push_back(c0);
        stim_q.push_back(c1);
        rejected = ((c % 32'd3) == 32'd0);
        if (rejected) begin
            if (exp_rej < 255) exp_rej++;
        end else begin
            exp_q.push_back(c);
        end
    endtask

    task automatic request(output bit got, output int valid_cyc);
        int cyc;
        got = 1'b0;
        valid_cyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        for (int a = 0; a < 8 && !got; a++) begin
            if (stim_q.size() < 2) break;
            rand_in = stim_q.pop_front();
            tick();
            rand_in = stim_q.pop_front();
            tick();
            rand_in = 16'($urandom);
            tick();
            cyc += 3;
            if (cand_valid === 1'b1) begin
                got = 1'b1;
                valid_cyc = cyc;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL request_valid: cand_valid=%b required 1", cand_valid);
        end
    endtask

    task automatic accept(input bit start_during);
        logic [31:0] exp;
        checks++;
        if (cand_valid !== 1'b1) begin
            errors++;
            $display("FAIL accept_valid: cand_valid=%b required 1", cand_valid);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL accept_scoreboard: cand_out=%h but no candidate expected", cand_out);
        end else begin
            exp = exp_q.pop_front();
            if (cand_out !== exp) begin
                errors++;
                $display("FAIL accept_cand_out: cand_out=%h required %h", cand_out, exp);
            end
        end
        checks++;
        if (reject_cnt !== 8'(exp_rej)) begin
            errors++;
            $display("FAIL accept_reject_cnt: reject_cnt=%0d required %0d", reject_cnt, exp_rej);
        end
        cand_ready = 1'b1;
        start = start_during;
        tick();
        cand_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (cand_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: cand_valid=%b busy=%b required 0 0", cand_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_during_handshake: busy=%b required 0", busy);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        start = 1'b0;
        cand_ready = 1'b0;
        rand_in = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        exp_rej = 0;
        stim_q.delete();
        exp_q.delete();
        tick();
    endtask

    task automatic test_reset();
        bit bad;
        reset_dut();
        checks++;
        if (busy !== 1'b0 || cand_valid !== 1'b0 || cand_out !== 32'h0 || reject_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_values: busy=%b valid=%b out=%h rej=%0d required 0 0 0 0",
                     busy, cand_valid, cand_out, reject_cnt);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_in = 16'($urandom);
            cand_ready = i[0];
            tick();
            if (busy !== 1'b0 || cand_valid !== 1'b0 || cand_out !== 32'h0 || reject_cnt !== 8'h0) bad = 1'b1;
        end
        cand_ready = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle_stable: outputs changed without start, last busy=%b valid=%b out=%h", busy, cand_valid, cand_out);
        end
    endtask

    task automatic test_accept();
        bit rj, got;
        int vc;
        plan(16'h1234, 16'h5679, rj);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL accept_idle: busy=%b required 0", busy);
        end
        request(got, vc);
        checks++;
        if (vc != 4) begin
            errors++;
            $display("FAIL accept_latency: valid at cycle %0d required 4", vc);
        end
        checks++;
        if (cand_out !== 32'hD6791235 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_value: cand_out=%h busy=%b required d6791235 1", cand_out, busy);
        end
        accept(1'b0);
    endtask

    task automatic test_reject_then_accept();
        bit rj, got;
        int vc;
        plan(16'h1234, 16'h5678, rj);
        plan(16'h0002, 16'h0000, rj);
        request(got, vc);
        checks++;
        if (vc != 7 || cand_out !== 32'h80000003 || reject_cnt !== 8'd1) begin
            errors++;
            $display("FAIL reject_accept: cycle=%0d out=%h rej=%0d required 7 80000003 1", vc, cand_out, reject_cnt);
        end
        accept(1'b0);
    endtask

    task automatic test_backpressure();
        bit rj, got, bad;
        int vc;
        plan(16'hBEEF, 16'h0102, rj);
        request(got, vc);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            cand_ready = 1'b0;
            tick();
            if (cand_valid !== 1'b1 || exp_q.size() == 0 || cand_out !== exp_q[0] || busy !== 1'b1) bad = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL backpressure_hold: cand_valid=%b cand_out=%h busy=%b not held", cand_valid, cand_out, busy);
        end
        accept(1'b1);
    endtask

    task automatic test_reset_mid();
        bit rj, got;
        int vc;
        start = 1'b1;
        tick();
        start = 1'b0;
        rand_in = 16'hAAAA;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || cand_out !== 32'h0 || cand_valid !== 1'b0 || reject_cnt !== 8'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b out=%h valid=%b rej=%0d required 0 0 0 0", busy, cand_out, cand_valid, reject_cnt);
        end
        tick();
        rst = 1'b0;
        exp_rej = 0;
        stim_q.delete();
        exp_q.delete();
        tick();
        plan(16'h1111, 16'h2222, rj);
        request(got, vc);
        checks++;
        if (cand_out !== 32'hA2221111) begin
            errors++;
            $display("FAIL post_reset_cand: cand_out=%h required a2221111", cand_out);
        end
        accept(1'b0);
    endtask

    task automatic test_random();
        bit rj, got;
        int vc, tries;
        for (int n = 0; n < 4; n++) begin
            tries = 0;
            rj = 1'b1;
            while (rj && tries < 4) begin
                plan(16'($urandom), 16'($urandom), rj);
                tries++;
            end
            if (rj) plan(16'h1111, 16'h2222, rj);
            request(got, vc);
            accept(1'b0);
        end
    endtask

    task automatic test_saturation();
        bit bad;
        reset_dut();
        rand_in = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cand_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (reject_cnt !== 8'd10) begin
            errors++;
            $display("FAIL reject_count_10: reject_cnt=%0d required 10", reject_cnt);
        end
        for (int i = 0; i < 870; i++) begin
            tick();
            if (cand_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL saturation_valid: cand_valid rose during all-zero input");
        end
        checks++;
        if (reject_cnt !== 8'd255 || busy !== 1'b1) begin
            errors++;
            $display("FAIL saturation_cnt: reject_cnt=%0d busy=%b required 255 1", reject_cnt, busy);
        end
        reset_dut();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cand_ready = 1'b0;
        rand_in = 16'h0;
        test_reset();
        test_accept();
        test_reject_then_accept();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
